// File: rtl/vga_key_pkg.sv
// vga_key_pkg: shared definitions for the VGA key marker.
//   - coordinate widths (X 9 bits, Y 8 bits) and colour width (3 bits)
//   - base (X,Y) tables for the 16 marker channels
//   - FSM state typedef (CLEAR exists only with VGA_KEY_MARKER_CLEAR_EN)
package vga_key_pkg;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;
  localparam int KEY_W    = 4;   // enough to index 16 channels
  localparam int MAX_KEYS = 16;

  // Channels 0..11 are the piano keys; 12..15 are octave+/-, ADSR+/-.
  localparam logic [X_W-1:0] BASE_X_TBL [0:MAX_KEYS-1] = '{
    9'd66,  9'd81,  9'd99,  9'd112, 9'd131, 9'd161, 9'd174, 9'd192,
    9'd209, 9'd224, 9'd245, 9'd254, 9'd103, 9'd71,  9'd153, 9'd183
  };

  localparam logic [Y_W-1:0] BASE_Y_TBL [0:MAX_KEYS-1] = '{
    8'd124, 8'd96,  8'd124, 8'd96,  8'd124, 8'd124, 8'd96,  8'd124,
    8'd96,  8'd124, 8'd96,  8'd124, 8'd169, 8'd169, 8'd169, 8'd169
  };

`ifdef VGA_KEY_MARKER_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/vga_key_coord.sv
// vga_key_coord: combinational channel index -> marker base coordinate.
// Ports:
//   key_idx : in  5 bits, channel index (values >= 16 map to (0,0))
//   base_x  : out 9 bits, marker top-left X
//   base_y  : out 8 bits, marker top-left Y
module vga_key_coord
  import vga_key_pkg::*;
(
  input  logic [4:0]     key_idx,
  output logic [X_W-1:0] base_x,
  output logic [Y_W-1:0] base_y
);

  always_comb begin
    base_x = '0;
    base_y = '0;
    if (key_idx < 5'd16) begin
      base_x = BASE_X_TBL[key_idx[3:0]];
      base_y = BASE_Y_TBL[key_idx[3:0]];
    end
  end

endmodule

// File: rtl/vga_key_marker.sv
// vga_key_marker: draws a BOX_W x BOX_H marker for every channel whose
// iKeyMask level differs from what is currently shown, one channel per
// visit to IDLE, lowest index first. One pixel per clock, column fastest.
//
// Optional feature: define VGA_KEY_MARKER_CLEAR_EN to erase every channel's
// marker after reset release before accepting key changes.
//
// Ports:
//   iClock   : in  clock, all state on rising edge
//   iResetn  : in  synchronous active-low reset
//   iKeyMask : in  NUM_KEYS levels, 1 = pressed
//   oX, oY   : out registered pixel coordinate
//   oColour  : out registered pixel colour
//   oPlot    : out registered pixel write enable
//   oBusy    : out high whenever the FSM is not in IDLE
module vga_key_marker
  import vga_key_pkg::*;
#(
  parameter int                    NUM_KEYS     = 16,
  parameter int                    BOX_W        = 4,
  parameter int                    BOX_H        = 4,
  parameter logic [COLOUR_W-1:0]   DRAW_COLOUR  = 3'b110,
  parameter logic [COLOUR_W-1:0]   ERASE_COLOUR = 3'b000
) (
  input  logic                iClock,
  input  logic                iResetn,
  input  logic [NUM_KEYS-1:0] iKeyMask,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy
);

  localparam int NPIX  = BOX_W * BOX_H;
  localparam int CNT_W = ($clog2(NPIX) > 0) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [3:0]       LAST_COL = 4'(BOX_W - 1);

  state_e                state_q, state_d;
  logic [NUM_KEYS-1:0]   shown_q, shown_d;
  logic [KEY_W-1:0]      key_q, key_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            col_q, col_d;
  logic [3:0]            row_q, row_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  plot_q, plot_d;
  logic                  busy_q, busy_d;
`ifdef VGA_KEY_MARKER_CLEAR_EN
  logic                  clear_pend_q, clear_pend_d;
`endif

  logic [NUM_KEYS-1:0]   diff;
  logic [KEY_W-1:0]      first_key;
  logic                  first_mode;
  logic                  emit;
  logic [X_W-1:0]        base_x;
  logic [Y_W-1:0]        base_y;

  // Coordinates for the pixel being registered come from the channel
  // selected this cycle, so the first pixel can leave on the latch edge.
  vga_key_coord u_coord (
    .key_idx ({1'b0, key_d}),
    .base_x  (base_x),
    .base_y  (base_y)
  );

  // Lowest-index channel whose requested level differs from the screen.
  always_comb begin
    diff       = iKeyMask ^ shown_q;
    first_key  = '0;
    first_mode = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (diff[i]) begin
        first_key  = KEY_W'(i);
        first_mode = iKeyMask[i];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q (or an idle value) so no branch can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    shown_d  = shown_q;
    key_d    = key_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    emit     = 1'b0;
`ifdef VGA_KEY_MARKER_CLEAR_EN
    clear_pend_d = clear_pend_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef VGA_KEY_MARKER_CLEAR_EN
        if (clear_pend_q) begin
          clear_pend_d = 1'b0;
          state_d      = CLEAR;
          key_d        = '0;
          mode_d       = 1'b0;
          cnt_d        = '0;
          col_d        = '0;
          row_d        = '0;
          emit         = 1'b1;
        end else
`endif
        if (|diff) begin
          state_d = DRAW;
          key_d   = first_key;
          mode_d  = first_mode;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          emit    = 1'b1;
        end
      end

      DRAW: begin
        if (cnt_q == LAST_PIX) begin
          // Last pixel is on the outputs this cycle: commit and go idle,
          // which guarantees one oPlot=0 cycle before the next box.
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_q == KEY_W'(i)) shown_d[i] = mode_q;
          end
          state_d = IDLE;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
          emit = 1'b1;
        end
      end

`ifdef VGA_KEY_MARKER_CLEAR_EN
      CLEAR: begin
        // Back-to-back erase boxes for every channel; shown stays all-zero.
        if (cnt_q == LAST_PIX) begin
          cnt_d = '0;
          col_d = '0;
          row_d = '0;
          if (key_q == KEY_W'(NUM_KEYS - 1)) begin
            state_d = IDLE;
          end else begin
            key_d = key_q + KEY_W'(1);
            emit  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
          emit = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Sums wrap silently at the port width.
    if (emit) begin
      plot_d   = 1'b1;
      x_d      = base_x + X_W'(col_d);
      y_d      = base_y + Y_W'(row_d);
      colour_d = mode_d ? DRAW_COLOUR : ERASE_COLOUR;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block; all state here is assigned with <= only.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q  <= IDLE;
      shown_q  <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef VGA_KEY_MARKER_CLEAR_EN
      clear_pend_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      shown_q  <= shown_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
`ifdef VGA_KEY_MARKER_CLEAR_EN
      clear_pend_q <= clear_pend_d;
`endif
    end
  end

  assign oX      = x_q;
  assign oY      = y_q;
  assign oColour = colour_q;
  assign oPlot   = plot_q;
  assign oBusy   = busy_q;

endmodule

// File: tb/tb_vga_key_marker.sv
// Scoreboard bench for vga_key_marker: directed stimulus pushes expected
// pixels into per-DUT queues; monitors pop and compare on every oPlot.
// dut_a uses default parameters, dut_b uses a 3x2 box.
module tb_vga_key_marker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, rstn_b;
  logic [15:0] mask_a, mask_b;
  logic [8:0]  x_a, x_b;
  logic [7:0]  y_a, y_b;
  logic [2:0]  c_a, c_b;
  logic        plot_a, plot_b, busy_a, busy_b;

  vga_key_marker dut_a (
    .iClock(clk), .iResetn(rstn_a), .iKeyMask(mask_a),
    .oX(x_a), .oY(y_a), .oColour(c_a), .oPlot(plot_a), .oBusy(busy_a)
  );

  vga_key_marker #(.NUM_KEYS(16), .BOX_W(3), .BOX_H(2)) dut_b (
    .iClock(clk), .iResetn(rstn_b), .iKeyMask(mask_b),
    .oX(x_b), .oY(y_b), .oColour(c_b), .oPlot(plot_b), .oBusy(busy_b)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t q_a[$];
  pix_t q_b[$];
  pix_t e_a, e_b;

  int n_cmp  = 0;
  int n_fail = 0;

  int bx [16] = '{66, 81, 99, 112, 131, 161, 174, 192, 209, 224, 245, 254, 103, 71, 153, 183};
  int by [16] = '{124, 96, 124, 96, 124, 124, 96, 124, 96, 124, 96, 124, 169, 169, 169, 169};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_box(input int sel, input int k, input int colour, input int n);
    int   w;
    pix_t e;
    w = (sel != 0) ? 3 : 4;
    for (int p = 0; p < n; p++) begin
      e.x = 9'(bx[k] + (p % w));
      e.y = 8'(by[k] + (p / w));
      e.c = 3'(colour);
      if (sel != 0) q_b.push_back(e);
      else          q_a.push_back(e);
    end
  endtask

  task automatic push_clear(input int sel);
    for (int k = 0; k < 16; k++) push_box(sel, k, 0, (sel != 0) ? 6 : 16);
  endtask

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  // Waits (bounded) for oBusy to rise, then counts its high cycles.
  task automatic measure(input int sel, input string name, input int exp_len);
    int t, n;
    t = 0;
    n = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy_of(sel) && t < 20);
    if (!busy_of(sel)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: busy never rose within 20 cycles", name);
    end else begin
      while (busy_of(sel) && n < 400) begin
        n++;
        @(negedge clk);
      end
      check(name, n, exp_len);
    end
  endtask

  // Monitors: plot must track busy, and every plotted pixel must match
  // the head of the scoreboard queue.
  always @(negedge clk) begin
    check("plot_eq_busy_a", int'(plot_a), int'(busy_a));
    if (plot_a) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_plot_a: got (%0d,%0d) c=%0d, expected no pixel", x_a, y_a, c_a);
      end else begin
        e_a = q_a.pop_front();
        check("pix_x_a", int'(x_a), int'(e_a.x));
        check("pix_y_a", int'(y_a), int'(e_a.y));
        check("pix_c_a", int'(c_a), int'(e_a.c));
      end
    end
  end

  always @(negedge clk) begin
    check("plot_eq_busy_b", int'(plot_b), int'(busy_b));
    if (plot_b) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_plot_b: got (%0d,%0d) c=%0d, expected no pixel", x_b, y_b, c_b);
      end else begin
        e_b = q_b.pop_front();
        check("pix_x_b", int'(x_b), int'(e_b.x));
        check("pix_y_b", int'(y_b), int'(e_b.y));
        check("pix_c_b", int'(c_b), int'(e_b.c));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    mask_a = '0;
    mask_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", int'(x_a), 0);
    check("rst_y", int'(y_a), 0);
    check("rst_colour", int'(c_a), 0);
    check("rst_plot", int'(plot_a), 0);
    check("rst_busy", int'(busy_a), 0);

    @(posedge clk) #1 rstn_a = 1'b1;
`ifdef VGA_KEY_MARKER_CLEAR_EN
    push_clear(0);
    measure(0, "clear_len_a", 256);
`endif

    // Press key 0: pressed colour, 4x4 at (66,124).
    @(posedge clk) #1;
    push_box(0, 0, 6, 16);
    mask_a[0] = 1'b1;
    measure(0, "press0_len", 16);
    repeat (5) @(negedge clk);
    check("press0_no_redraw", int'(busy_a), 0);
    check("hold_x", int'(x_a), 69);
    check("hold_y", int'(y_a), 127);
    check("hold_colour", int'(c_a), 6);

    // Release key 0: same box in erase colour.
    @(posedge clk) #1;
    push_box(0, 0, 0, 16);
    mask_a[0] = 1'b0;
    measure(0, "release0_len", 16);
    repeat (5) @(negedge clk);
    check("release0_no_redraw", int'(busy_a), 0);

    // Keys 1 and 3 together: key 1 first, a gap, then key 3.
    @(posedge clk) #1;
    push_box(0, 1, 6, 16);
    push_box(0, 3, 6, 16);
    mask_a = 16'h000A;
    measure(0, "multi_first_len", 16);
    check("multi_gap_plot", int'(plot_a), 0);
    measure(0, "multi_second_len", 16);

    // Key 5 pulses while key 0 draws: no box for key 5.
    @(posedge clk) #1;
    push_box(0, 0, 6, 16);
    mask_a[0] = 1'b1;
    t = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy_a) t++;
      if (c == 3) mask_a[5] = 1'b1;
      if (c == 8) mask_a[5] = 1'b0;
    end
    check("glitch_busy_len", t, 16);

    // Reset at pixel 7 of the key-2 box.
    @(posedge clk) #1;
    push_box(0, 2, 6, 8);
    mask_a[2] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy_a && t < 20);
    check("abort_box_started", int'(busy_a), 1);
    repeat (7) @(negedge clk);
    rstn_a = 1'b0;
    mask_a = 16'h0001;
    @(negedge clk);
    check("abort_plot", int'(plot_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_x", int'(x_a), 0);
    check("abort_y", int'(y_a), 0);
    @(posedge clk) #1 rstn_a = 1'b1;
`ifdef VGA_KEY_MARKER_CLEAR_EN
    push_clear(0);
`endif
    // shown was cleared, so the held key 0 is redrawn.
    push_box(0, 0, 6, 16);
`ifdef VGA_KEY_MARKER_CLEAR_EN
    measure(0, "abort_clear_len", 256);
`endif
    measure(0, "after_reset_len", 16);

    // 3x2 box on channel 12 with the second instance.
`ifdef VGA_KEY_MARKER_CLEAR_EN
    push_clear(1);
`endif
    push_box(1, 12, 6, 6);
    @(posedge clk) #1;
    mask_b[12] = 1'b1;
    rstn_b     = 1'b1;
`ifdef VGA_KEY_MARKER_CLEAR_EN
    measure(1, "clear_len_b", 96);
`endif
    measure(1, "small_box_len", 6);

    repeat (4) @(negedge clk);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
